// File: rtl/mtr_pkg.sv
// Shared motor-drive types and constants for the PWM duty decoder and its helpers.
package mtr_pkg;

    localparam logic [11:0] DUTY_MID       = 12'h800;
    localparam int          DEF_PWM_PERIOD = 4096;

    typedef enum logic {ACQ, LOCK} pwm_dec_state_t;

    typedef logic signed [11:0] spd_t;

endpackage

// File: rtl/pwm_sync.sv
// Two-flop synchronizer for an asynchronous PWM pin. A third flop provides a
// rising-edge pulse that is aligned with the synchronized level.
module pwm_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures PWM1 high time per PWM period and publishes duty/speed once per window.
// Define PWM_OVLP_CHK_EN to add PWM1/PWM2 overlap detection and publish suppression.
//
// state | meaning
// ACQ   | free-running window, waiting for a PWM1 rise to align to
// LOCK  | window aligned to PWM1 rise; an off-position rise restarts it
module pwm_duty_decoder
    import mtr_pkg::*;
#(
    parameter int PERIOD = DEF_PWM_PERIOD,
    parameter bit INVERT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PWM1,
    input  logic        PWM2,
    input  logic        clr_err,
    output logic [11:0] duty,
    output spd_t        spd,
    output logic        vld,
    output logic        locked,
    output logic        sync_err,
    output logic        ovlp_err
);

    localparam int            WW = $clog2(PERIOD);
    localparam int            SH = 12 - WW;
    localparam logic [WW-1:0] TC = WW'(PERIOD - 1);

    logic w_p1;
    logic w_rise;
    logic w_ovlp;

    pwm_sync u_sync_pwm1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (PWM1),
        .o_sync  (w_p1),
        .o_rise  (w_rise)
    );

`ifdef PWM_OVLP_CHK_EN
    logic w_p2;
    logic w_unused_rise2;
    logic r_ovlp_err;

    pwm_sync u_sync_pwm2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (PWM2),
        .o_sync  (w_p2),
        .o_rise  (w_unused_rise2)
    );

    assign w_ovlp = w_p1 & w_p2;

    // Set has priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_ovlp_err <= 1'b0;
        else if (w_ovlp)  r_ovlp_err <= 1'b1;
        else if (clr_err) r_ovlp_err <= 1'b0;
    end

    assign ovlp_err = r_ovlp_err;
`else
    logic w_unused_pwm2;

    assign w_unused_pwm2 = PWM2;
    assign w_ovlp        = 1'b0;
    assign ovlp_err      = 1'b0;
`endif

    pwm_dec_state_t    r_state;
    logic [WW-1:0]     r_wcnt;
    logic [WW:0]       r_hcnt;
    logic              r_rise_seen;
    logic              r_miss_win;
    logic              r_ovlp_win;

    logic              w_tc;
    logic [WW:0]       w_hnext;
    logic [WW-1:0]     w_hsat;
    logic [11:0]       w_duty_new;
    logic signed [12:0] w_spd_wide;
    spd_t              w_spd_new;

    assign w_tc    = (r_wcnt == TC);
    assign w_hnext = r_hcnt + (WW+1)'(w_p1);
    assign w_hsat  = w_hnext[WW] ? TC : w_hnext[WW-1:0];

    always_comb begin
        w_duty_new = 12'(w_hsat) << SH;
        if (INVERT)
            w_spd_wide = $signed({1'b0, DUTY_MID}) - $signed({1'b0, w_duty_new});
        else
            w_spd_wide = $signed({1'b0, w_duty_new}) - $signed({1'b0, DUTY_MID});
        // Only INVERT with duty 0 reaches +2048.
        w_spd_new = (w_spd_wide > 13'sd2047) ? 12'sh7FF : w_spd_wide[11:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACQ;
            r_wcnt      <= '0;
            r_hcnt      <= '0;
            r_rise_seen <= 1'b0;
            r_miss_win  <= 1'b0;
            r_ovlp_win  <= 1'b0;
            duty        <= DUTY_MID;
            spd         <= '0;
            vld         <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            vld <= 1'b0;
            if (clr_err) sync_err <= 1'b0;

            // A rise anywhere except the wrap position realigns the window.
            if (w_rise && (r_state == ACQ || r_wcnt != '0)) begin
                if (r_state == LOCK) sync_err <= 1'b1;
                r_state     <= LOCK;
                locked      <= 1'b1;
                r_wcnt      <= WW'(1);
                r_hcnt      <= (WW+1)'(1);
                r_rise_seen <= 1'b1;
                r_miss_win  <= 1'b0;
                r_ovlp_win  <= w_ovlp;
            end else begin
                r_wcnt <= r_wcnt + WW'(1);
                if (w_rise) r_rise_seen <= 1'b1;
                if (w_tc) begin
                    r_hcnt     <= '0;
                    r_ovlp_win <= 1'b0;
                    if (!(r_ovlp_win || w_ovlp)) begin
                        duty <= w_duty_new;
                        spd  <= w_spd_new;
                        vld  <= 1'b1;
                    end
                    if (r_state == LOCK) begin
                        r_rise_seen <= 1'b0;
                        if (r_rise_seen) begin
                            r_miss_win <= 1'b0;
                        end else if (r_miss_win) begin
                            r_state    <= ACQ;
                            locked     <= 1'b0;
                            r_miss_win <= 1'b0;
                        end else begin
                            r_miss_win <= 1'b1;
                        end
                    end
                end else begin
                    r_hcnt     <= w_hnext;
                    r_ovlp_win <= r_ovlp_win | w_ovlp;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Random-duty bench for pwm_duty_decoder: two instances (left and right speed
// convention) share the PWM pins; published values are compared to a duty model.
module tb_pwm_duty_decoder;

    localparam int P     = 256;
    localparam int LOG2P = $clog2(P);
`ifdef PWM_OVLP_CHK_EN
    localparam bit OVLP_ON = 1'b1;
`else
    localparam bit OVLP_ON = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        PWM1    = 1'b0;
    logic        PWM2    = 1'b0;
    logic        clr_err = 1'b0;
    logic [11:0] duty_a, spd_a, duty_b, spd_b;
    logic        vld_a, locked_a, sync_err_a, ovlp_err_a;
    logic        vld_b, locked_b, sync_err_b, ovlp_err_b;

    int n_chk = 0;
    int n_err = 0;
    int n_exp = 0;
    int n_vld_a = 0;
    int n_vld_b = 0;
    int exp_q[$];
    int first;

    always #5 clk = ~clk;

    pwm_duty_decoder #(.PERIOD(P), .INVERT(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .PWM1(PWM1), .PWM2(PWM2), .clr_err(clr_err),
        .duty(duty_a), .spd(spd_a), .vld(vld_a), .locked(locked_a),
        .sync_err(sync_err_a), .ovlp_err(ovlp_err_a)
    );

    pwm_duty_decoder #(.PERIOD(P), .INVERT(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .PWM1(PWM1), .PWM2(PWM2), .clr_err(clr_err),
        .duty(duty_b), .spd(spd_b), .vld(vld_b), .locked(locked_b),
        .sync_err(sync_err_b), .ovlp_err(ovlp_err_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Duty of a period with h high cycles: saturate to PERIOD-1, scale to 12 bits.
    function automatic int exp_duty(input int h);
        int s;
        s = (h > P - 1) ? P - 1 : h;
        return (s * (4096 / P)) % 4096;
    endfunction

    function automatic int exp_spd(input int d, input bit inv);
        int v;
        v = inv ? 2048 - d : d - 2048;
        if (v > 2047) v = 2047;
        return (v + 4096) % 4096;
    endfunction

    task automatic step(input logic p1, input logic p2, input logic clr, output bit got_vld);
        int h;
        int d;
        @(negedge clk);
        got_vld = vld_a;
        if (vld_a) begin
            n_vld_a++;
            if (exp_q.size() > 0) begin
                h = exp_q.pop_front();
                d = exp_duty(h);
                chk("duty", duty_a, d);
                chk("spd", spd_a, exp_spd(d, 1'b0));
                chk("duty_inv", duty_b, d);
                chk("spd_inv", spd_b, exp_spd(d, 1'b1));
            end
        end
        if (vld_b) n_vld_b++;
        PWM1    = p1;
        PWM2    = p2;
        clr_err = clr;
    endtask

    // One PWM period with complementary PWM2 and dead time; optional extra PWM1
    // pulse, forced PWM2 overlap, early stop and clr_err pulse.
    task automatic run_period(input int h, input int glitch, input int ovlp,
                              input int len, input bit pub, input int clr_at);
        bit v;
        logic p1, p2;
        if (pub) begin
            exp_q.push_back(h);
            n_exp++;
        end
        for (int p = 0; p < len; p++) begin
            p1 = (p < h) || (glitch >= 0 && p >= glitch && p < glitch + 3);
            p2 = (glitch < 0) && (p >= h + 2) && (p <= P - 3);
            if (ovlp >= 0 && p >= ovlp && p < ovlp + 5) p2 = 1'b1;
            step(p1, p2, (p == clr_at), v);
        end
    endtask

    // PWM1 held at a constant level for nwin windows (0% or 100% duty).
    task automatic hold(input logic lvl, input int nwin, input int h_model,
                        input int n_pub, output int first_vld);
        bit v;
        first_vld = -1;
        for (int i = 0; i < n_pub; i++) begin
            exp_q.push_back(h_model);
            n_exp++;
        end
        for (int i = 1; i <= nwin * P; i++) begin
            step(lvl, 1'b0, 1'b0, v);
            if (v && first_vld < 0) first_vld = i;
            if (i == P) chk("locked_mid", locked_a, int'(lvl));
        end
        chk("locked_end", locked_a, 0);
    endtask

    task automatic do_reset();
        #2;
        rst_n   = 1'b0;
        PWM1    = 1'b0;
        PWM2    = 1'b0;
        clr_err = 1'b0;
        #1;
        chk("rst_duty", duty_a, 'h800);
        chk("rst_spd", spd_a, 0);
        chk("rst_duty_inv", duty_b, 'h800);
        chk("rst_spd_inv", spd_b, 0);
        chk("rst_vld", vld_a, 0);
        chk("rst_locked", locked_a, 0);
        chk("rst_sync_err", sync_err_a, 0);
        chk("rst_ovlp_err", ovlp_err_a, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic end_phase(input string tag);
        chk({tag, "_nvld"}, n_vld_a, n_exp);
        chk({tag, "_nvld_inv"}, n_vld_b, n_exp);
        n_vld_a = 0;
        n_vld_b = 0;
        n_exp   = 0;
        exp_q.delete();
    endtask

    initial begin
        do_reset();

        hold(1'b0, 3, 0, 3, first);
        chk("first_vld_low", first, P);
        end_phase("zero");

        // Rise reaches the window 3 clk after the pin; window completes P clk later.
        hold(1'b1, 4, P, 3, first);
        chk("first_vld_high", first, P + 3);
        chk("sync_err_high", sync_err_a, 0);
        end_phase("full");

        do_reset();
        run_period(P / 2, -1, -1, P, 1'b1, -1);
        run_period(3 * P / 4, -1, -1, P, 1'b1, -1);
        for (int k = 0; k < 10; k++)
            run_period(int'($urandom_range(P - 1, 1)), -1, -1, P, 1'b1, -1);
        chk("locked_run", locked_a, 1);
        chk("sync_err_run", sync_err_a, 0);
        chk("ovlp_err_run", ovlp_err_a, 0);

        run_period(P / 4, 100, -1, P, 1'b0, -1);
        chk("sync_err_set", sync_err_a, 1);
        chk("locked_glitch", locked_a, 1);
        run_period(int'($urandom_range(P - 1, 1)), -1, -1, P, 1'b1, -1);
        run_period(int'($urandom_range(P - 1, 1)), -1, -1, P, 1'b1, 50);
        chk("sync_err_clr", sync_err_a, 0);

        run_period(40, -1, 10, P, !OVLP_ON, -1);
        chk("ovlp_err", ovlp_err_a, int'(OVLP_ON));
        run_period(int'($urandom_range(P - 1, 1)), -1, -1, P, 1'b1, -1);
        run_period(int'($urandom_range(P - 1, 1)), -1, -1, 100, 1'b0, -1);
        end_phase("run");

        do_reset();
        hold(1'b0, 2, 0, 2, first);
        chk("first_vld_post_rst", first, P);
        end_phase("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
